// File: rtl/mod_n_counter_ctrl.sv
// Modulo-N run controller: counts 0..max, wrapping for cfg_laps laps (0 = forever); pause gated by MODN_CTRL_PAUSE_EN.
// Latency: counter is 0 after the start edge and 1 after the next; outputs are registered or decoded from state.
// Backpressure: none; stop aborts at once, pause (when enabled) is a level that freezes the count.
module mod_n_counter_ctrl #(
    parameter int N      = 6,
    parameter int LENGTH = 3,
    parameter int LAPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [LENGTH-1:0] cfg_max,
    input  logic [LAPS_W-1:0] cfg_laps,
    output logic [LENGTH-1:0] counter,
    output logic              wrap,
    output logic [LAPS_W-1:0] lap,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LENGTH-1:0] DEF_MAX = LENGTH'(N - 1);

    state_t            state, state_nxt;
    logic [LENGTH-1:0] max_q, max_nxt, counter_nxt;
    logic [LAPS_W-1:0] laps_q, laps_nxt, lap_nxt, lap_inc;
    logic              wrap_nxt;

    assign lap_inc = lap + LAPS_W'(1);
    assign busy    = (state == RUN) || (state == PAUSE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            lap     <= '0;
            wrap    <= 1'b0;
            max_q   <= '0;
            laps_q  <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            lap     <= lap_nxt;
            wrap    <= wrap_nxt;
            max_q   <= max_nxt;
            laps_q  <= laps_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        lap_nxt     = lap;
        wrap_nxt    = 1'b0;
        max_nxt     = max_q;
        laps_nxt    = laps_q;
        case (state)
            IDLE: begin
                counter_nxt = '0;
                // Configuration is captured only here, so mid-run cfg changes are inert.
                if (start) begin
                    state_nxt = RUN;
                    max_nxt   = (cfg_max == '0) ? DEF_MAX : cfg_max;
                    laps_nxt  = cfg_laps;
                    lap_nxt   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end
`ifdef MODN_CTRL_PAUSE_EN
                else if (pause) begin
                    state_nxt = PAUSE;
                end
`endif
                else if (counter == max_q) begin
                    counter_nxt = '0;
                    wrap_nxt    = 1'b1;
                    lap_nxt     = lap_inc;
                    if ((laps_q != '0) && (lap_inc == laps_q)) begin
                        state_nxt = DONE;
                    end
                end else begin
                    counter_nxt = counter + LENGTH'(1);
                end
            end
            PAUSE: begin
`ifdef MODN_CTRL_PAUSE_EN
                // Leaving PAUSE costs one edge; counting resumes on the edge after.
                if (stop) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
`else
                state_nxt   = IDLE;
                counter_nxt = '0;
`endif
            end
            DONE: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end
        endcase
    end

endmodule
